// File: rtl/multdiv_pkg.sv
// Shared constants for the iterative multiply/divide unit and its decode/writeback users.
package multdiv_pkg;

    // FSM state encodings
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // R-type ALU_op codes that launch the unit
    localparam logic [4:0] ALU_OP_MUL = 5'b00110;
    localparam logic [4:0] ALU_OP_DIV = 5'b00111;

    // Register written with data_exception ($rstatus)
    localparam logic [4:0] RSTATUS_REG = 5'd30;

endpackage

// File: rtl/div_step.sv
// One iteration of unsigned restoring division: shift in the next dividend bit,
// subtract the divisor when it fits, and report the quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   new_rem,
    output logic             quotient_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;

    // Trial subtraction; restore (keep the shifted value) when the divisor does not fit
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
        shifted      = {rem, dividend_bit};
        diff         = shifted[WIDTH:0] - {1'b0, divisor};
        quotient_bit = (shifted >= {2'b00, divisor});
        new_rem      = quotient_bit ? diff : shifted[WIDTH:0];
    end

endmodule

// File: rtl/multdiv_seq.sv
// Iterative signed multiply/divide unit. A one-cycle ctrl_MULT/ctrl_DIV pulse
// latches the operand magnitudes; WIDTH shift-add or restoring-divide iterations
// follow, then a one-cycle data_resultRDY strobe with the sign-corrected result.
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         state;
    logic [CNT_W-1:0]   count;
    // MUL: {partial product, remaining multiplier bits}; DIV: low half shifts dividend
    // bits out of the top while quotient bits enter at the bottom.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   mag_op;      // multiplicand for MUL, divisor for DIV
    logic               neg_result;
    logic               div_exc;

    logic               start;
    logic               last_iter;
    logic [WIDTH-1:0]   mag_a_in;
    logic [WIDTH-1:0]   mag_b_in;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rem_next;
    logic               div_qbit;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic               mul_ovf;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign last_iter = (count == CNT_W'(WIDTH - 1));

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem          (rem),
        .dividend_bit (acc[WIDTH-1]),
        .divisor      (mag_op),
        .new_rem      (div_rem_next),
        .quotient_bit (div_qbit)
    );

    // Operand magnitudes (INT_MIN maps to 2^(WIDTH-1) as an unsigned value) and one datapath step
    always_comb begin
        mag_a_in = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        mag_b_in = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_op} : '0);
        acc_next = acc;
        if (state == MUL) begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end else if (state == DIV) begin
            acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_qbit};
        end
        product  = neg_result ? -acc_next : acc_next;
        quotient = neg_result ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
        mul_ovf  = (product[2*WIDTH-1:WIDTH-1] != '0) && (product[2*WIDTH-1:WIDTH-1] != '1);
    end

    // FSM, iteration counter, datapath registers and registered outputs
    always_ff @(posedge clock) begin
        // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            acc            <= '0;
            rem            <= '0;
            mag_op         <= '0;
            neg_result     <= 1'b0;
            div_exc        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (start) begin
                count      <= '0;
                rem        <= '0;
                neg_result <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                if (ctrl_MULT) begin
                    state   <= MUL;
                    mag_op  <= mag_a_in;
                    acc     <= {{WIDTH{1'b0}}, mag_b_in};
                    div_exc <= 1'b0;
                end else begin
                    state   <= DIV;
                    mag_op  <= mag_b_in;
                    acc     <= {{WIDTH{1'b0}}, mag_a_in};
                    div_exc <= (data_operandB == '0) ||
                               ((data_operandA == INT_MIN) && (data_operandB == '1));
                end
            end else begin
                case (state)
                    MUL, DIV: begin
                        acc   <= acc_next;
                        count <= count + CNT_W'(1);
                        if (state == DIV) begin
                            rem <= div_rem_next;
                        end
                        if (last_iter) begin
                            state          <= DONE;
                            data_resultRDY <= 1'b1;
                            if (state == MUL) begin
                                data_result    <= product[WIDTH-1:0];
                                data_exception <= mul_ovf;
                            end else if (div_exc) begin
                                data_result    <= '0;
                                data_exception <= 1'b1;
                            end else begin
                                data_result    <= quotient;
                                data_exception <= 1'b0;
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
